sitcpxg_tx_arbiter: RTL and testbench
=====================================

Name: sitcpxg_tx_arbiter

Overview:
- Round-robin scheduler sharing the SiTCPXG TCP transmit port (USER_TX_D/USER_TX_B) among N user data channels.
- Grants one channel at a time, for one burst of up to MAX_BURST words.
- Honours USER_TX_AFULL back-pressure and session state.
- Sits between user data producers and the SiTCPXG core, in the XGMII_CLOCK domain.

Parameters:
- N, 4, number of requesting channels (2..8).
- MAX_BURST, 64, max 64-bit words per grant before re-arbitration (1..255).

Ports:
- XGMII_CLOCK  in  1  system clock (156.25 MHz).
- RSTn  in  1  reset, asynchronous, active-low.
- SESSION_ESTABLISHED  in  1  from USER_SESSION_ESTABLISHED.
- USER_TX_AFULL  in  1  from SiTCPXG core.
- CH_REQ  in  N  channel i has data pending.
- CH_VALID  in  N  CH_TX_D/CH_TX_B slice i valid this cycle.
- CH_LAST  in  N  qualifies the last word of channel i's current packet.
- CH_TX_D  in  64*N  data, slice i = [64i+63:64i].
- CH_TX_B  in  4*N  byte count 1..8, slice i = [4i+3:4i].
- CH_RDY  out  N  word accepted from channel i when CH_VALID[i] & CH_RDY[i].
- CH_ABORT  out  N  one-cycle pulse: channel i's burst cut by session loss.
- USER_TX_D  out  64  to SiTCPXG core.
- USER_TX_B  out  4  to SiTCPXG core; 0 = no write.
- GRANT_ID  out  3  currently/last granted channel.
- BUSY  out  1  state != IDLE.

Behaviour:
- Reset (RSTn low, async): state IDLE, rr pointer = N-1, word count 0, all outputs 0.
- State IDLE:
  - If SESSION_ESTABLISHED & ~USER_TX_AFULL & |CH_REQ, pick the first requester searching from pointer+1 upward with wrap.
  - Load GRANT_ID, set pointer = winner, clear word count, go to XFER (or HDR with the optional feature).
- State XFER:
  - CH_RDY[g] = SESSION_ESTABLISHED & ~USER_TX_AFULL. This is combinational from registered state and inputs; all other CH_RDY bits are 0.
  - On accept: USER_TX_D/USER_TX_B are registered from slice g the next cycle (latency 1 cycle); count += 1.
  - No accept: USER_TX_B = 0 the next cycle.
- Burst end:
  - Accept with CH_LAST[g], or accept making count == MAX_BURST, returns to IDLE.
  - Re-arbitration can grant no earlier than the cycle after IDLE is entered, giving a minimum 1 idle cycle between grants.
  - A burst cut at MAX_BURST mid-packet is legal: the channel re-requests and resumes when next granted, and the round-robin turn passes to others first.
- CH_REQ dropping during XFER does not end the burst; only LAST, MAX_BURST or session loss end it.
- USER_TX_AFULL high: CH_RDY drops in the same cycle. The SiTCPXG core tolerates the word already registered. The grant is held; no timeout.
- Session loss (SESSION_ESTABLISHED low) in XFER/HDR:
  - Pulse CH_ABORT[g] for 1 cycle, go to IDLE, USER_TX_B = 0 next cycle.
  - The partial packet is the channel's responsibility.
- Simultaneous LAST and session loss on the same cycle: the word is NOT accepted (CH_RDY already 0); CH_ABORT pulses.
- Count width: 8 bits, never wraps; it is compared for equality against MAX_BURST.
- CH_TX_B values of 0 or >8 from a valid channel are forwarded unchanged. Checking them is not this block's job.

Optional Feature:
- Macro SITCPXG_TXARB_HDR_EN.
- Defined:
  - After a grant, state HDR emits one 8-byte header word with USER_TX_B = 8 before the data, when ~USER_TX_AFULL & SESSION_ESTABLISHED.
  - Header layout: bits [63:56] = 8'hA5, [55:48] = GRANT_ID zero-extended, [47:32] = 16-bit per-channel burst sequence number (increments per grant, wraps 16'hFFFF to 0, reset 0), [31:0] = 0.
  - HDR stalls while AFULL is high; the header does not count toward MAX_BURST.
- Undefined: no HDR state; IDLE goes directly to XFER; no sequence counters are synthesised.

Test Plan:
- Single channel: CH_REQ=4'b0001, 5 words B=8, LAST on word 5 -> USER_TX_B=8 for 5 cycles, 1 cycle after each accept, then BUSY=0; GRANT_ID=0.
- Fairness: CH_REQ=4'b1111 continuously, each channel sends 1-word packets -> grant order 0,1,2,3,0,1 with 1 idle cycle between bursts.
- MAX_BURST=4, channel 2 streams 10 words with no LAST while channel 3 requests -> 4 words from ch2, then ch3 burst, then ch2 resumes with word 5.
- AFULL asserted for 3 cycles mid-burst -> CH_RDY[g]=0 in exactly those 3 cycles, no words lost or duplicated, transfer resumes in order.
- SESSION_ESTABLISHED dropped after word 2 of 6 -> CH_ABORT[g] one-cycle pulse, no further USER_TX_B != 0, next grant only after session returns.
- HDR_EN defined, channel 1 granted twice -> header words 64'hA501_0000_0000_0000 then 64'hA501_0001_0000_0000; RSTn pulsed low asynchronously mid-burst -> outputs 0 immediately, sequence restarts at 0.

Source files
------------

// File: rtl/sitcpxg_tx_arbiter.sv
// Round-robin arbiter sharing the SiTCPXG TCP transmit port among N user channels.
// Optional burst header (state HDR plus per-channel sequence counters) under `SITCPXG_TXARB_HDR_EN.
module sitcpxg_tx_arbiter #(
    parameter int N         = 4,
    parameter int MAX_BURST = 64
) (
    input  logic             XGMII_CLOCK,
    input  logic             RSTn,
    input  logic             SESSION_ESTABLISHED,
    input  logic             USER_TX_AFULL,
    input  logic [N-1:0]     CH_REQ,
    input  logic [N-1:0]     CH_VALID,
    input  logic [N-1:0]     CH_LAST,
    input  logic [64*N-1:0]  CH_TX_D,
    input  logic [4*N-1:0]   CH_TX_B,
    output logic [N-1:0]     CH_RDY,
    output logic [N-1:0]     CH_ABORT,
    output logic [63:0]      USER_TX_D,
    output logic [3:0]       USER_TX_B,
    output logic [2:0]       GRANT_ID,
    output logic             BUSY
);

`ifdef SITCPXG_TXARB_HDR_EN
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, HDR = 2'd2} state_t;
`else
    typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;
`endif

    state_t       state_q, state_d;
    logic [2:0]   ptr_q, ptr_d;
    logic [2:0]   gnt_q, gnt_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [63:0]  tx_d_q, tx_d_d;
    logic [3:0]   tx_b_q, tx_b_d;
    logic [N-1:0] abort_q, abort_d;

    logic         can_go;
    logic         accept;
    logic [N-1:0] gnt_onehot;
    logic [63:0]  sel_d;
    logic [3:0]   sel_b;
    logic         sel_valid;
    logic         sel_last;
    logic         req_found;
    logic [2:0]   winner;

    assign can_go     = SESSION_ESTABLISHED & ~USER_TX_AFULL;
    assign gnt_onehot = N'(1) << gnt_q;

    always_comb begin
        sel_d     = '0;
        sel_b     = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q == 3'(i)) begin
                sel_d     = CH_TX_D[64*i +: 64];
                sel_b     = CH_TX_B[4*i +: 4];
                sel_valid = CH_VALID[i];
                sel_last  = CH_LAST[i];
            end
        end
    end

    // First requester strictly after the pointer, wrapping; the last winner is searched last.
    always_comb begin
        int idx;
        idx       = 0;
        req_found = 1'b0;
        winner    = ptr_q;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!req_found && CH_REQ[idx]) begin
                req_found = 1'b1;
                winner    = 3'(idx);
            end
        end
    end

    // Handshake: a word moves from channel g when CH_VALID[g] & CH_RDY[g] are both high
    // at a rising edge; CH_RDY never depends on CH_VALID, so there is no combinational loop.
    assign CH_RDY = (state_q == XFER && can_go) ? gnt_onehot : '0;
    assign accept = (state_q == XFER) && can_go && sel_valid;

`ifdef SITCPXG_TXARB_HDR_EN
    logic [15:0] seq_q [N];
    logic [15:0] seq_d [N];
    logic [15:0] seq_sel;

    always_comb begin
        seq_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q == 3'(i)) seq_sel = seq_q[i];
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        tx_d_d  = tx_d_q;
        tx_b_d  = '0;
        abort_d = '0;
`ifdef SITCPXG_TXARB_HDR_EN
        seq_d   = seq_q;
`endif
        case (state_q)
            IDLE: begin
                if (can_go && req_found) begin
                    gnt_d = winner;
                    ptr_d = winner;
                    cnt_d = '0;
`ifdef SITCPXG_TXARB_HDR_EN
                    state_d = HDR;
`else
                    state_d = XFER;
`endif
                end
            end
`ifdef SITCPXG_TXARB_HDR_EN
            HDR: begin
                if (!SESSION_ESTABLISHED) begin
                    abort_d = gnt_onehot;
                    state_d = IDLE;
                end else if (!USER_TX_AFULL) begin
                    tx_d_d  = {8'hA5, 5'd0, gnt_q, seq_sel, 32'd0};
                    tx_b_d  = 4'd8;
                    for (int i = 0; i < N; i++) begin
                        if (gnt_q == 3'(i)) seq_d[i] = seq_q[i] + 16'd1;
                    end
                    state_d = XFER;
                end
            end
`endif
            XFER: begin
                if (!SESSION_ESTABLISHED) begin
                    abort_d = gnt_onehot;
                    state_d = IDLE;
                end else if (accept) begin
                    tx_d_d = sel_d;
                    tx_b_d = sel_b;
                    cnt_d  = cnt_q + 8'd1;
                    if (sel_last || cnt_d == 8'(MAX_BURST)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            ptr_q   <= 3'(N-1);
            gnt_q   <= '0;
            cnt_q   <= '0;
            tx_d_q  <= '0;
            tx_b_q  <= '0;
            abort_q <= '0;
`ifdef SITCPXG_TXARB_HDR_EN
            for (int i = 0; i < N; i++) seq_q[i] <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            tx_d_q  <= tx_d_d;
            tx_b_q  <= tx_b_d;
            abort_q <= abort_d;
`ifdef SITCPXG_TXARB_HDR_EN
            seq_q   <= seq_d;
`endif
        end
    end

    assign USER_TX_D = tx_d_q;
    assign USER_TX_B = tx_b_q;
    assign GRANT_ID  = gnt_q;
    assign CH_ABORT  = abort_q;
    assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_sitcpxg_tx_arbiter.sv
// Directed bench for sitcpxg_tx_arbiter (default build, MAX_BURST = 4) with an expected-word scoreboard.
module tb_sitcpxg_tx_arbiter;
    localparam int N  = 4;
    localparam int MB = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sess;
    logic             afull;
    logic [N-1:0]     ch_req, ch_valid, ch_last, ch_rdy, ch_abort;
    logic [64*N-1:0]  ch_tx_d;
    logic [4*N-1:0]   ch_tx_b;
    logic [63:0]      tx_d;
    logic [3:0]       tx_b;
    logic [2:0]       gid;
    logic             busy;

    always #5 clk = ~clk;

    sitcpxg_tx_arbiter #(.N(N), .MAX_BURST(MB)) dut (
        .XGMII_CLOCK         (clk),
        .RSTn                (rst_n),
        .SESSION_ESTABLISHED (sess),
        .USER_TX_AFULL       (afull),
        .CH_REQ              (ch_req),
        .CH_VALID            (ch_valid),
        .CH_LAST             (ch_last),
        .CH_TX_D             (ch_tx_d),
        .CH_TX_B             (ch_tx_b),
        .CH_RDY              (ch_rdy),
        .CH_ABORT            (ch_abort),
        .USER_TX_D           (tx_d),
        .USER_TX_B           (tx_b),
        .GRANT_ID            (gid),
        .BUSY                (busy)
    );

    // Source entry: {last, byte count, data}
    logic [68:0]  src_mem [N][16];
    int           rd_p [N];
    int           wr_p [N];
    logic [67:0]  exp_q [$];
    int           wr_cyc [$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           n_fired = 0;
    logic [N-1:0] fire;

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            rd_p[i] = 0;
            wr_p[i] = 0;
        end
        n_fired = 0;
        wr_cyc.delete();
    endtask

    task automatic add_word(input int ch, input logic last, input logic [3:0] b);
        logic [63:0] d;
        d = {8'(ch), 8'(wr_p[ch]), 16'hBEEF, 32'($urandom())};
        src_mem[ch][wr_p[ch]] = {last, b, d};
        wr_p[ch]++;
    endtask

    task automatic exp_word(input int ch, input int idx);
        exp_q.push_back(src_mem[ch][idx][67:0]);
    endtask

    task automatic present();
        for (int i = 0; i < N; i++) begin
            if (rd_p[i] < wr_p[i]) begin
                ch_valid[i]          = 1'b1;
                ch_req[i]            = 1'b1;
                ch_last[i]           = src_mem[i][rd_p[i]][68];
                ch_tx_b[4*i +: 4]    = src_mem[i][rd_p[i]][67:64];
                ch_tx_d[64*i +: 64]  = src_mem[i][rd_p[i]][63:0];
            end else begin
                ch_valid[i] = 1'b0;
                ch_req[i]   = 1'b0;
                ch_last[i]  = 1'b0;
            end
        end
    endtask

    function automatic logic pending();
        logic p;
        p = 1'b0;
        for (int i = 0; i < N; i++) if (rd_p[i] < wr_p[i]) p = 1'b1;
        return p;
    endfunction

    // One clock: note which word the coming edge accepts, then score the output it produces.
    task automatic step();
        logic [67:0] e;
        #1;
        fire = ch_valid & ch_rdy;
        @(negedge clk);
        cyc++;
        if (fire != '0) begin
            n_fired++;
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("extra_word", {tx_b, tx_d}, 68'd0);
            end else begin
                e = exp_q.pop_front();
                check("word", {tx_b, tx_d}, e);
            end
        end else begin
            check("idle_b", 68'(tx_b), 68'd0);
        end
        for (int i = 0; i < N; i++) if (fire[i]) rd_p[i]++;
        present();
    endtask

    task automatic run(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || pending()) && k < budget) begin
            step();
            k++;
        end
        check("timeout", 68'(k < budget), 68'd1);
        step();
        step();
        check("end_busy", 68'(busy), 68'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        sess     = 1'b1;
        afull    = 1'b0;
        ch_req   = '0;
        ch_valid = '0;
        ch_last  = '0;
        ch_tx_d  = '0;
        ch_tx_b  = '0;
        clear_src();
        #1;
        check("rst_tx_b", 68'(tx_b), 68'd0);
        check("rst_tx_d", 68'(tx_d), 68'd0);
        check("rst_busy", 68'(busy), 68'd0);
        check("rst_gid", 68'(gid), 68'd0);
        check("rst_rdy", 68'(ch_rdy), 68'd0);
        check("rst_abort", 68'(ch_abort), 68'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fairness: 1-word packets from all channels, one idle cycle between grants
        clear_src();
        add_word(0, 1'b1, 4'd8); add_word(0, 1'b1, 4'd8);
        add_word(1, 1'b1, 4'd8); add_word(1, 1'b1, 4'd8);
        add_word(2, 1'b1, 4'd8);
        add_word(3, 1'b1, 4'd8);
        exp_word(0, 0); exp_word(1, 0); exp_word(2, 0);
        exp_word(3, 0); exp_word(0, 1); exp_word(1, 1);
        present();
        run(40);
        check("fair_count", 68'(wr_cyc.size()), 68'd6);
        for (int i = 1; i < wr_cyc.size(); i++)
            check("fair_gap", 68'(wr_cyc[i] - wr_cyc[i-1]), 68'd2);
        check("fair_gid", 68'(gid), 68'd1);

        // Single channel: back-to-back words, LAST ends the burst
        clear_src();
        add_word(0, 1'b0, 4'd8); add_word(0, 1'b0, 4'd8); add_word(0, 1'b1, 4'd8);
        for (int i = 0; i < 3; i++) exp_word(0, i);
        present();
        run(20);
        check("single_count", 68'(wr_cyc.size()), 68'd3);
        for (int i = 1; i < wr_cyc.size(); i++)
            check("single_gap", 68'(wr_cyc[i] - wr_cyc[i-1]), 68'd1);
        check("single_gid", 68'(gid), 68'd0);

        // MAX_BURST cut: ch2 streams 10 words, ch3 gets its turn after 4
        clear_src();
        for (int i = 0; i < 10; i++)
            add_word(2, i == 9, (i == 3) ? 4'hF : ((i == 6) ? 4'd1 : 4'd8));
        add_word(3, 1'b0, 4'd5); add_word(3, 1'b1, 4'd8);
        for (int i = 0; i < 4; i++) exp_word(2, i);
        exp_word(3, 0); exp_word(3, 1);
        for (int i = 4; i < 10; i++) exp_word(2, i);
        present();
        run(80);
        check("max_count", 68'(wr_cyc.size()), 68'd12);

        // AFULL for 3 cycles mid-burst
        clear_src();
        for (int i = 0; i < 4; i++) add_word(1, i == 3, 4'd8);
        for (int i = 0; i < 4; i++) exp_word(1, i);
        present();
        for (int k = 0; k < 20 && n_fired < 2; k++) step();
        check("afull_reach", 68'(n_fired), 68'd2);
        afull = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("afull_rdy", 68'(ch_rdy), 68'd0);
            step();
        end
        afull = 1'b0;
        #1;
        check("afull_resume_rdy", 68'(ch_rdy), 68'b0010);
        run(20);

        // Session loss after word 2 of 6
        clear_src();
        for (int i = 0; i < 6; i++) add_word(3, i == 5, 4'd8);
        for (int i = 0; i < 6; i++) exp_word(3, i);
        present();
        for (int k = 0; k < 20 && n_fired < 2; k++) step();
        check("sess_reach", 68'(n_fired), 68'd2);
        sess = 1'b0;
        step();
        check("abort_pulse", 68'(ch_abort), 68'b1000);
        check("abort_busy", 68'(busy), 68'd0);
        step();
        check("abort_clear", 68'(ch_abort), 68'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("sess_low_busy", 68'(busy), 68'd0);
        end
        check("sess_low_words", 68'(n_fired), 68'd2);
        sess = 1'b1;
        run(40);
        check("sess_total", 68'(n_fired), 68'd6);

        // Asynchronous reset mid-burst, then pointer restarts at N-1
        clear_src();
        for (int i = 0; i < 3; i++) add_word(2, i == 2, 4'd8);
        exp_word(2, 0);
        present();
        for (int k = 0; k < 20 && n_fired < 1; k++) step();
        check("arst_reach", 68'(n_fired), 68'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tx_b", 68'(tx_b), 68'd0);
        check("arst_busy", 68'(busy), 68'd0);
        check("arst_gid", 68'(gid), 68'd0);
        check("arst_rdy", 68'(ch_rdy), 68'd0);
        exp_q.delete();
        clear_src();
        add_word(1, 1'b1, 4'd8);
        add_word(3, 1'b1, 4'd8);
        exp_word(1, 0);
        exp_word(3, 0);
        present();
        @(negedge clk);
        rst_n = 1'b1;
        run(20);
        check("arst_gid_final", 68'(gid), 68'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
